shiftreg_ctrl: RTL and testbench
================================

Name: shiftreg_ctrl

Overview:
Sequencer for one shiftreg instance. It accepts parallel words over a valid/ready handshake, loads each word into the shift register, and issues WIDTH paced shift strobes at a programmable divider rate. After the last bit it pulses a latch strobe and enforces an inter-word gap. It sits between a word source (e.g. a FIFO) and the shiftreg that drives a serial output pin.

Parameters:
WIDTH, 10, word width in bits; must match the controlled shiftreg (>=1)
DIV, 4, clock cycles per shift strobe (>=1); DIV=1 means a shift every cycle
GAP, 2, idle cycles between LATCH and the next accept (>=0)

Ports:
clock_in  input  1  system clock, all logic on rising edge
reset_in  input  1  synchronous reset, active high
word_valid_in  input  1  source has a word
word_data_in  input  WIDTH  word to serialize
word_ready_out  output  1  controller can accept a word
pause_in  input  1  freezes the divider and the bit counter while in SHIFT
sr_load_out  output  1  to shiftreg load_in, one-cycle pulse
sr_shift_out  output  1  to shiftreg shift_in, one-cycle pulses
sr_data_out  output  WIDTH  to shiftreg data_in, registered copy of the accepted word
sr_done_in  input  1  from shiftreg done_out; used only by the optional check
latch_out  output  1  one-cycle strobe after the final shift
busy_out  output  1  high in every state except IDLE
error_out  output  1  sticky protocol-check flag (see Optional Feature)

Behaviour:
- Reset (reset_in=1 at an edge, any state, including mid-word): state IDLE; divider and bit counter cleared.
  - Reset output values: word_ready_out=1; sr_load_out=0; sr_shift_out=0; latch_out=0; busy_out=0; sr_data_out=0; error_out=0.
- Reset overrides every other input in the same cycle. No partial word completes.
- The FSM has five states: IDLE, LOAD, SHIFT, LATCH, GAP. All outputs are registered or decoded from state only, with no combinational input-to-output paths.
- IDLE:
  - word_ready_out=1.
  - On an edge with word_valid_in=1: capture word_data_in into sr_data_out and go to LOAD.
  - sr_data_out holds its value until the next accept.
- LOAD (1 cycle): sr_load_out=1. Clear the divider and the bit counter. Go to SHIFT.
- SHIFT:
  - The divider counts 0..DIV-1.
  - sr_shift_out=1 in the cycle where divider==DIV-1 and pause_in=0. The bit counter increments on that cycle.
  - When pause_in=1, the divider and bit counter hold and sr_shift_out=0.
  - After the WIDTH-th strobe, go to LATCH.
- LATCH (1 cycle): latch_out=1. If GAP>0, go to GAP; otherwise go to IDLE.
- GAP: stay GAP cycles, then go to IDLE.
- word_ready_out=0 in every state except IDLE. word_valid_in is ignored outside IDLE.
- Timing for an accept at edge T, with no pause:
  - load pulse in cycle T+1
  - first shift strobe in cycle T+1+DIV
  - last (WIDTH-th) shift strobe in cycle T+1+WIDTH*DIV
  - latch_out in cycle T+2+WIDTH*DIV
  - word_ready_out high again at cycle T+3+WIDTH*DIV+GAP
- Back-to-back word period: WIDTH*DIV+GAP+3 cycles (45 with the defaults).
- Exactly WIDTH shift strobes occur per word, never more. Pulses are never merged: load, shift and latch are mutually exclusive in any cycle.
- Counter widths are $clog2 of max(DIV,2) and of WIDTH+1. No counter wrap-around is observable.

Optional Feature:
- Macro: SHIFTREG_CTRL_DONE_CHECK_EN
- When defined:
  - error_out is set if sr_done_in=1 in the first SHIFT cycle after LOAD.
  - error_out is also set if sr_done_in=0 in the LATCH cycle.
  - error_out stays set until reset_in. The sequencing itself is unaffected.
- When undefined: error_out is tied 0 and sr_done_in is unused.

Test Plan:
- Reset with word_valid_in=0 -> word_ready_out=1, busy_out=0, and all strobes 0. After 20 idle cycles no strobes have occurred.
- Defaults; accept 10'h2A5 at T -> sr_data_out=10'h2A5; load at T+1; 10 shift strobes at T+5, T+9, …, T+41; latch at T+42; word_ready_out=1 at T+45.
- word_valid_in held high for 3 words -> accepts at T, T+45 and T+90; exactly 30 shift strobes and 3 latch pulses in total.
- pause_in=1 for 7 cycles starting just before the 3rd strobe -> that strobe and all later events are delayed by exactly 7 cycles, with still exactly 10 strobes.
- reset_in pulsed after the 4th strobe -> outputs return to reset values the next cycle with no latch pulse. A following word runs a full, normal 10-strobe sequence.
- With the macro defined, drive sr_done_in=0 in LATCH -> error_out=1 from the next cycle and sticky until reset. With the macro undefined -> error_out stays 0.

Source files
------------

// File: rtl/shiftreg_ctrl.sv
// shiftreg_ctrl: accepts words, then paces load, WIDTH shift strobes, latch and an idle gap for one shiftreg.
// Define SHIFTREG_CTRL_DONE_CHECK_EN to enable the sticky sr_done_in protocol check on error_out.
module shiftreg_ctrl #(
  parameter int WIDTH = 10,
  parameter int DIV = 4,
  parameter int GAP = 2
) (
  input  logic             clock_in,
  input  logic             reset_in,
  input  logic             word_valid_in,
  input  logic [WIDTH-1:0] word_data_in,
  output logic             word_ready_out,
  input  logic             pause_in,
  output logic             sr_load_out,
  output logic             sr_shift_out,
  output logic [WIDTH-1:0] sr_data_out,
  input  logic             sr_done_in,
  output logic             latch_out,
  output logic             busy_out,
  output logic             error_out
);
  localparam int DW = $clog2(DIV > 2 ? DIV : 2);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int GW = $clog2(GAP + 2);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_LATCH, S_GAP} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] div_q, div_d, div_nx;
  logic [BW-1:0] bit_q, bit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic shift_q, shift_d;
  logic last_bit;
  assign div_nx = (div_q == DW'(DIV - 1)) ? '0 : div_q + 1'b1;
  assign last_bit = shift_q && (bit_q == BW'(WIDTH - 1));
  // The strobe is registered: it is decided one edge ahead from the divider's next value.
  always_comb begin
    state_d = state_q;
    div_d = div_q;
    bit_d = bit_q;
    gap_d = gap_q;
    data_d = data_q;
    shift_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = word_valid_in ? S_LOAD : S_IDLE;
        data_d = word_valid_in ? word_data_in : data_q;
      end
      S_LOAD: begin
        state_d = S_SHIFT;
        div_d = '0;
        bit_d = '0;
        shift_d = (DIV == 1);
      end
      S_SHIFT: begin
        bit_d = bit_q + BW'(shift_q);
        if (last_bit) state_d = S_LATCH;
        else if (!pause_in) begin
          div_d = div_nx;
          shift_d = (div_nx == DW'(DIV - 1));
        end
      end
      S_LATCH: begin
        state_d = (GAP > 0) ? S_GAP : S_IDLE;
        gap_d = '0;
      end
      S_GAP: begin
        state_d = (gap_q == GW'(GAP - 1)) ? S_IDLE : S_GAP;
        gap_d = gap_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q <= S_IDLE;
      div_q <= '0;
      bit_q <= '0;
      gap_q <= '0;
      data_q <= '0;
      shift_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      bit_q <= bit_d;
      gap_q <= gap_d;
      data_q <= data_d;
      shift_q <= shift_d;
    end
  end
  assign word_ready_out = (state_q == S_IDLE);
  assign busy_out = (state_q != S_IDLE);
  assign sr_load_out = (state_q == S_LOAD);
  assign latch_out = (state_q == S_LATCH);
  assign sr_shift_out = shift_q;
  assign sr_data_out = data_q;
`ifdef SHIFTREG_CTRL_DONE_CHECK_EN
  logic first_q, first_d, err_q, err_d;
  assign first_d = (state_q == S_LOAD);
  assign err_d = err_q | (state_q == S_SHIFT && first_q && sr_done_in) | (state_q == S_LATCH && !sr_done_in);
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      first_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      first_q <= first_d;
      err_q <= err_d;
    end
  end
  assign error_out = err_q;
`else
  logic unused_done;
  assign unused_done = sr_done_in;
  assign error_out = 1'b0;
`endif
endmodule

// File: tb/tb_shiftreg_ctrl.sv
// tb_shiftreg_ctrl: drives input tables (directed then random) and checks every cycle against an event schedule.
module tb_shiftreg_ctrl;
  localparam int W = 10, D = 4, G = 2, N = 2500, M = N + 400;
  logic clk = 1'b0;
  logic rst, valid, pause, done, ready, load, shift, latch, busy, err;
  logic [W-1:0] din, dout;
  always #5 clk = ~clk;
  shiftreg_ctrl #(.WIDTH(W), .DIV(D), .GAP(G)) dut (
    .clock_in(clk), .reset_in(rst), .word_valid_in(valid), .word_data_in(din),
    .word_ready_out(ready), .pause_in(pause), .sr_load_out(load), .sr_shift_out(shift),
    .sr_data_out(dout), .sr_done_in(done), .latch_out(latch), .busy_out(busy), .error_out(err)
  );
  bit t_valid[N], t_pause[N], t_rst[N], t_done[N];
  logic [W-1:0] t_din[N];
  bit e_ready[M], e_load[M], e_shift[M], e_latch[M], e_err[M];
  logic [W-1:0] e_data[M];
  int idle_from;
  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pz(input int k);
    return (k < N) ? t_pause[k] : 1'b0;
  endfunction

  // A word accepted in cycle c: load next cycle, then every D unpaused cycles (load cycle counts) one strobe.
  task automatic schedule(input int c);
    int l = c + 1, k = c + 1, adv = 0;
    e_load[l] = 1'b1;
    for (int s = 1; s <= W; s++) begin
      while (adv < s * D) begin
        if (k == l || !pz(k)) adv++;
        k++;
      end
      e_shift[k] = 1'b1;
    end
    e_latch[k + 1] = 1'b1;
    for (int j = l; j <= k + 1 + G; j++) e_ready[j] = 1'b0;
    idle_from = k + 2 + G;
  endtask

  initial begin
    int n_s, n_l;
    for (int c = 0; c < N; c++) begin
      t_valid[c] = 1'b0;
      t_pause[c] = 1'b0;
      t_rst[c] = 1'b0;
      t_din[c] = W'($urandom);
    end
    t_valid[20] = 1'b1;
    t_din[20] = 10'h2A5;
    for (int c = 100; c <= 190; c++) t_valid[c] = 1'b1;
    t_valid[300] = 1'b1;
    for (int c = 312; c <= 318; c++) t_pause[c] = 1'b1;
    t_valid[400] = 1'b1;
    t_rst[418] = 1'b1;
    t_valid[430] = 1'b1;
    for (int c = 500; c < N; c++) begin
      t_valid[c] = ($urandom_range(0, 2) == 0);
      t_pause[c] = ($urandom_range(0, 7) == 0);
      t_rst[c] = ($urandom_range(0, 399) == 0);
    end
    for (int j = 0; j < M; j++) begin
      e_ready[j] = 1'b1;
      e_load[j] = 1'b0;
      e_shift[j] = 1'b0;
      e_latch[j] = 1'b0;
      e_err[j] = 1'b0;
      e_data[j] = '0;
    end
    idle_from = 0;
    for (int c = 0; c < N; c++) begin
      if (t_rst[c]) begin
        for (int j = c + 1; j < idle_from; j++) begin
          e_ready[j] = 1'b1;
          e_load[j] = 1'b0;
          e_shift[j] = 1'b0;
          e_latch[j] = 1'b0;
        end
        if (idle_from > c + 1) idle_from = c + 1;
        e_data[c + 1] = '0;
      end else if (c >= idle_from && t_valid[c]) begin
        schedule(c);
        e_data[c + 1] = t_din[c];
      end else e_data[c + 1] = e_data[c];
    end
    for (int c = 0; c < N; c++) begin
      t_done[c] = e_latch[c] ^ (c >= 500 && $urandom_range(0, 299) == 0);
      if (c >= 200 && c < 300 && e_latch[c]) t_done[c] = 1'b0;
`ifdef SHIFTREG_CTRL_DONE_CHECK_EN
      e_err[c + 1] = t_rst[c] ? 1'b0 : (e_err[c] | (c > 0 && e_load[c - 1] && !e_ready[c] && t_done[c]) | (e_latch[c] && !t_done[c]));
`else
      e_err[c + 1] = 1'b0;
`endif
    end
    rst = 1'b1;
    valid = 1'b0;
    pause = 1'b0;
    done = 1'b0;
    din = '0;
    repeat (3) @(posedge clk);
    #1;
    n_s = 0;
    n_l = 0;
    for (int c = 0; c < N; c++) begin
      chk("ready", ready, e_ready[c]);
      chk("busy", busy, !e_ready[c]);
      chk("load", load, e_load[c]);
      chk("shift", shift, e_shift[c]);
      chk("latch", latch, e_latch[c]);
      chk("data", dout, e_data[c]);
      chk("error", err, e_err[c]);
      if (c == 21) chk("acc_data_2a5", dout, 10'h2A5);
      if (c == 21) chk("load_T1", load, 1);
      if (c == 24) chk("no_shift_T4", shift, 0);
      if (c == 25) chk("shift_T5", shift, 1);
      if (c == 61) chk("shift_T41", shift, 1);
      if (c == 62) chk("latch_T42", latch, 1);
      if (c == 64) chk("ready_T44", ready, 0);
      if (c == 65) chk("ready_T45", ready, 1);
      if (c == 146) chk("b2b_load2", load, 1);
      if (c == 191) chk("b2b_load3", load, 1);
      if (c == 313) chk("pause_no_shift", shift, 0);
      if (c == 320) chk("pause_shift3", shift, 1);
      if (c == 349) chk("pause_latch", latch, 1);
      if (c == 419) chk("rst_busy", busy, 0);
      if (c == 419) chk("rst_data", dout, 0);
      if (c == 100 || c == 400 || c == 431) begin
        n_s = 0;
        n_l = 0;
      end
      n_s += int'(shift);
      n_l += int'(latch);
      if (c == 299) chk("b2b_shifts", n_s, 30);
      if (c == 299) chk("b2b_latches", n_l, 3);
      if (c == 429) chk("rst_shifts", n_s, 4);
      if (c == 429) chk("rst_latches", n_l, 0);
      if (c == 499) chk("post_rst_shifts", n_s, 10);
      if (c == 499) chk("post_rst_latches", n_l, 1);
      rst = t_rst[c];
      valid = t_valid[c];
      din = t_din[c];
      pause = t_pause[c];
      done = t_done[c];
      @(posedge clk);
      #1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
